// File: rtl/decode_pkg.sv
// Shared encodings for the decode stage: operand/write-source selectors, major
// opcodes, the decoded control bundle and the fence-serialisation state.
package decode_pkg;

  localparam logic [2:0] ALU_SRC_ZERO     = 3'd0;
  localparam logic [2:0] ALU_SRC_PC_PLUS4 = 3'd1;
  localparam logic [2:0] ALU_SRC_PC       = 3'd2;
  localparam logic [2:0] ALU_SRC_REG      = 3'd3;
  localparam logic [2:0] ALU_SRC_IMM12    = 3'd4;
  localparam logic [2:0] ALU_SRC_IMM20    = 3'd5;
  localparam logic [2:0] ALU_SRC_XMM      = 3'd6;

  localparam logic [2:0] REG_WRITE_SRC_FPU_U32  = 3'd0;
  localparam logic [2:0] REG_WRITE_SRC_FPU_I32  = 3'd1;
  localparam logic [2:0] REG_WRITE_SRC_ALU      = 3'd2;
  localparam logic [2:0] REG_WRITE_SRC_MEM      = 3'd4;
  localparam logic [2:0] REG_WRITE_SRC_FPU_FP32 = 3'd6;

  localparam logic [2:0] XMM_WRITE_SRC_ALU_U32  = 3'd0;
  localparam logic [2:0] XMM_WRITE_SRC_ALU_I32  = 3'd1;
  localparam logic [2:0] XMM_WRITE_SRC_ALU_FP32 = 3'd2;
  localparam logic [2:0] XMM_WRITE_SRC_MEM      = 3'd4;
  localparam logic [2:0] XMM_WRITE_SRC_FPU      = 3'd6;

  localparam logic [1:0] MEM_WRITE_SRC_REG = 2'd1;
  localparam logic [1:0] MEM_WRITE_SRC_XMM = 2'd2;

  // Major opcodes, instr[6:2]
  localparam logic [4:0] OPC_LOAD     = 5'h00;
  localparam logic [4:0] OPC_LOAD_FP  = 5'h01;
  localparam logic [4:0] OPC_MISC_MEM = 5'h03;
  localparam logic [4:0] OPC_OP_IMM   = 5'h04;
  localparam logic [4:0] OPC_AUIPC    = 5'h05;
  localparam logic [4:0] OPC_STORE    = 5'h08;
  localparam logic [4:0] OPC_STORE_FP = 5'h09;
  localparam logic [4:0] OPC_OP       = 5'h0C;
  localparam logic [4:0] OPC_LUI      = 5'h0D;
  localparam logic [4:0] OPC_FMADD    = 5'h10;
  localparam logic [4:0] OPC_FMSUB    = 5'h11;
  localparam logic [4:0] OPC_FNMSUB   = 5'h12;
  localparam logic [4:0] OPC_FNMADD   = 5'h13;
  localparam logic [4:0] OPC_OP_FP    = 5'h14;
  localparam logic [4:0] OPC_BRANCH   = 5'h18;
  localparam logic [4:0] OPC_JALR     = 5'h19;
  localparam logic [4:0] OPC_JAL      = 5'h1B;

  // OP-FP funct5 groups, instr[31:27]
  localparam logic [4:0] F5_FCMP     = 5'h14;
  localparam logic [4:0] F5_FCVT_W_S = 5'h18;
  localparam logic [4:0] F5_FMV_X_W  = 5'h1C;
  localparam logic [4:0] F5_FCVT_S_W = 5'h1A;
  localparam logic [4:0] F5_FMV_W_X  = 5'h1E;

  typedef struct packed {
    logic [4:0] rs1_addr;
    logic [4:0] rs2_addr;
    logic [4:0] rs3_addr;
    logic [4:0] rd_addr;
    logic       read_mem;
    logic       write_mem;
    logic       write_reg;
    logic       write_xmm;
    logic [2:0] alu_a_src;
    logic [2:0] alu_b_src;
    logic [2:0] reg_write_src;
    logic [2:0] xmm_write_src;
    logic [1:0] mem_write_src;
    logic       is_branch;
    logic       is_jump;
    logic       is_fence;
    logic       illegal;
  } decoded_t;

  typedef enum logic {ST_RUN, ST_FENCE_WAIT} state_t;

endpackage

// File: rtl/instr_decode_comb.sv
// Pure combinational RV32I(+F) decoder: raw instruction word to control bundle.
// Illegal encodings keep register addresses but clear every enable and source.
module instr_decode_comb
  import decode_pkg::*;
#(
  parameter bit ENABLE_F = 1'b1
) (
  input  logic [31:0] instr,
  output decoded_t    dec
);

  logic [4:0] opc;
  logic [4:0] funct5;
  logic       ill;
  logic       unused_bits;

  assign opc         = instr[6:2];
  assign funct5      = instr[31:27];
  assign unused_bits = ^{instr[26:25], instr[14:12]};

  always_comb begin
    dec = '0;
    ill = 1'b0;
    if (instr[1:0] != 2'b11) begin
      ill = 1'b1;
    end else begin
      case (opc)
        OPC_LOAD: begin
          dec.read_mem = 1'b1; dec.write_reg = 1'b1;
          dec.alu_a_src = ALU_SRC_REG; dec.alu_b_src = ALU_SRC_IMM12;
          dec.reg_write_src = REG_WRITE_SRC_MEM;
        end
        OPC_MISC_MEM: dec.is_fence = 1'b1;
        OPC_OP_IMM: begin
          dec.write_reg = 1'b1; dec.alu_a_src = ALU_SRC_REG; dec.alu_b_src = ALU_SRC_IMM12;
          dec.reg_write_src = REG_WRITE_SRC_ALU;
        end
        OPC_AUIPC: begin
          dec.write_reg = 1'b1; dec.alu_a_src = ALU_SRC_PC; dec.alu_b_src = ALU_SRC_IMM20;
          dec.reg_write_src = REG_WRITE_SRC_ALU;
        end
        OPC_STORE: begin
          dec.write_mem = 1'b1; dec.alu_a_src = ALU_SRC_REG; dec.alu_b_src = ALU_SRC_IMM12;
          dec.mem_write_src = MEM_WRITE_SRC_REG;
        end
        OPC_OP: begin
          dec.write_reg = 1'b1; dec.alu_a_src = ALU_SRC_REG; dec.alu_b_src = ALU_SRC_REG;
          dec.reg_write_src = REG_WRITE_SRC_ALU;
        end
        OPC_LUI: begin
          dec.write_reg = 1'b1; dec.alu_a_src = ALU_SRC_ZERO; dec.alu_b_src = ALU_SRC_IMM20;
          dec.reg_write_src = REG_WRITE_SRC_ALU;
        end
        OPC_BRANCH: begin
          dec.alu_a_src = ALU_SRC_REG; dec.alu_b_src = ALU_SRC_REG; dec.is_branch = 1'b1;
        end
        OPC_JALR, OPC_JAL: begin
          dec.write_reg = 1'b1; dec.alu_a_src = ALU_SRC_PC_PLUS4; dec.alu_b_src = ALU_SRC_ZERO;
          dec.reg_write_src = REG_WRITE_SRC_ALU; dec.is_jump = 1'b1;
        end
        OPC_LOAD_FP: begin
          if (ENABLE_F) begin
            dec.read_mem = 1'b1; dec.write_xmm = 1'b1;
            dec.alu_a_src = ALU_SRC_REG; dec.alu_b_src = ALU_SRC_IMM12;
            dec.xmm_write_src = XMM_WRITE_SRC_MEM;
          end else ill = 1'b1;
        end
        OPC_STORE_FP: begin
          if (ENABLE_F) begin
            dec.write_mem = 1'b1; dec.alu_a_src = ALU_SRC_REG; dec.alu_b_src = ALU_SRC_IMM12;
            dec.mem_write_src = MEM_WRITE_SRC_XMM;
          end else ill = 1'b1;
        end
        OPC_FMADD, OPC_FMSUB, OPC_FNMSUB, OPC_FNMADD: begin
          if (ENABLE_F) begin
            dec.write_xmm = 1'b1; dec.alu_a_src = ALU_SRC_XMM; dec.alu_b_src = ALU_SRC_XMM;
            dec.xmm_write_src = XMM_WRITE_SRC_FPU;
          end else ill = 1'b1;
        end
        OPC_OP_FP: begin
          if (!ENABLE_F) begin
            ill = 1'b1;
          end else begin
            // Conversions pick signed/unsigned from rs2[0], i.e. instr[20]
            case (funct5)
              F5_FCMP: begin
                dec.write_reg = 1'b1; dec.reg_write_src = REG_WRITE_SRC_FPU_I32;
              end
              F5_FCVT_W_S: begin
                dec.write_reg = 1'b1;
                dec.reg_write_src = instr[20] ? REG_WRITE_SRC_FPU_U32 : REG_WRITE_SRC_FPU_I32;
              end
              F5_FMV_X_W: begin
                dec.write_reg = 1'b1; dec.reg_write_src = REG_WRITE_SRC_FPU_FP32;
              end
              F5_FCVT_S_W: begin
                dec.write_xmm = 1'b1; dec.alu_a_src = ALU_SRC_REG; dec.alu_b_src = ALU_SRC_ZERO;
                dec.xmm_write_src = instr[20] ? XMM_WRITE_SRC_ALU_U32 : XMM_WRITE_SRC_ALU_I32;
              end
              F5_FMV_W_X: begin
                dec.write_xmm = 1'b1; dec.alu_a_src = ALU_SRC_REG; dec.alu_b_src = ALU_SRC_ZERO;
                dec.xmm_write_src = XMM_WRITE_SRC_ALU_FP32;
              end
              default: begin
                dec.write_xmm = 1'b1; dec.alu_a_src = ALU_SRC_XMM; dec.alu_b_src = ALU_SRC_XMM;
                dec.xmm_write_src = XMM_WRITE_SRC_FPU;
              end
            endcase
          end
        end
        default: ill = 1'b1;
      endcase
    end
    if (ill) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
    dec.rs1_addr = instr[19:15];
    dec.rs2_addr = instr[24:20];
    dec.rs3_addr = instr[31:27];
    dec.rd_addr  = instr[11:7];
  end

endmodule

// File: rtl/instr_decode_queue.sv
// Registered decode stage: decodes the offered instruction and queues the bundle in
// a DEPTH-entry FIFO; a FENCE blocks intake until the queue drains and memory idles.
module instr_decode_queue
  import decode_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 2,
  parameter bit ENABLE_F = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  input  logic            mem_idle,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic [4:0]      out_rs1_addr,
  output logic [4:0]      out_rs2_addr,
  output logic [4:0]      out_rs3_addr,
  output logic [4:0]      out_rd_addr,
  output logic            out_read_mem,
  output logic            out_write_mem,
  output logic            out_write_reg,
  output logic            out_write_xmm,
  output logic [2:0]      out_alu_a_src,
  output logic [2:0]      out_alu_b_src,
  output logic [2:0]      out_reg_write_src,
  output logic [2:0]      out_xmm_write_src,
  output logic [1:0]      out_mem_write_src,
  output logic            out_is_branch,
  output logic            out_is_jump,
  output logic            out_illegal
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  decoded_t        dec_p0;
  decoded_t        dec_p1   [DEPTH];
  logic [XLEN-1:0] pc_p1    [DEPTH];
  logic [31:0]     instr_p1 [DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             vld_p1, full, push, pop;
  state_t           state, state_nxt;

  decoded_t        head_dec;
  logic [XLEN-1:0] head_pc;
  logic [31:0]     head_instr;

  instr_decode_comb #(.ENABLE_F(ENABLE_F)) u_decode (
    .instr (in_instr),
    .dec   (dec_p0)
  );

  assign vld_p1 = (count != '0);
  assign full   = (count == CNT_W'(DEPTH));
  assign push   = in_valid && in_ready;
  assign pop    = vld_p1 && out_ready;

  // p0 -> p1: decoded bundle enters the FIFO
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      dec_p1[wr_ptr]   <= dec_p0;
      pc_p1[wr_ptr]    <= in_pc;
      instr_p1[wr_ptr] <= in_instr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_RUN;
    end else begin
      case (state)
        ST_RUN:        if (push && dec_p0.is_fence) state_nxt = ST_FENCE_WAIT;
        ST_FENCE_WAIT: if (!vld_p1 && mem_idle)      state_nxt = ST_RUN;
        default:       state_nxt = ST_RUN;
      endcase
    end
  end

  always_comb begin
    in_ready = !full && (state == ST_RUN) && !flush;
  end

  // Head is masked when empty so stale storage never reaches execute
  always_comb begin
    head_dec   = '0;
    head_pc    = '0;
    head_instr = '0;
    if (vld_p1) begin
      head_dec   = dec_p1[rd_ptr];
      head_pc    = pc_p1[rd_ptr];
      head_instr = instr_p1[rd_ptr];
    end
  end

  assign out_valid         = vld_p1;
  assign out_pc            = head_pc;
  assign out_instr         = head_instr;
  assign out_rs1_addr      = head_dec.rs1_addr;
  assign out_rs2_addr      = head_dec.rs2_addr;
  assign out_rs3_addr      = head_dec.rs3_addr;
  assign out_rd_addr       = head_dec.rd_addr;
  assign out_read_mem      = head_dec.read_mem;
  assign out_write_mem     = head_dec.write_mem;
  assign out_write_reg     = head_dec.write_reg;
  assign out_write_xmm     = head_dec.write_xmm;
  assign out_alu_a_src     = head_dec.alu_a_src;
  assign out_alu_b_src     = head_dec.alu_b_src;
  assign out_reg_write_src = head_dec.reg_write_src;
  assign out_xmm_write_src = head_dec.xmm_write_src;
  assign out_mem_write_src = head_dec.mem_write_src;
  assign out_is_branch     = head_dec.is_branch;
  assign out_is_jump       = head_dec.is_jump;
  assign out_illegal       = head_dec.illegal;

endmodule

// File: tb/tb_instr_decode_queue.sv
// Bench for instr_decode_queue: directed scenarios plus a randomized run against a
// queue-based reference model (one instance with F enabled, one without).
module tb_instr_decode_queue;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, in_valid, flush, mem_idle, out_ready;
  logic [31:0] in_instr, in_pc;

  logic        in_ready, out_valid;
  logic [31:0] out_pc, out_instr;
  logic [4:0]  out_rs1_addr, out_rs2_addr, out_rs3_addr, out_rd_addr;
  logic        out_read_mem, out_write_mem, out_write_reg, out_write_xmm;
  logic [2:0]  out_alu_a_src, out_alu_b_src, out_reg_write_src, out_xmm_write_src;
  logic [1:0]  out_mem_write_src;
  logic        out_is_branch, out_is_jump, out_illegal;

  logic        nf_in_ready, nf_out_valid;
  logic [31:0] nf_out_pc, nf_out_instr;
  logic [4:0]  nf_rs1, nf_rs2, nf_rs3, nf_rd;
  logic        nf_read_mem, nf_write_mem, nf_write_reg, nf_write_xmm;
  logic [2:0]  nf_alu_a, nf_alu_b, nf_reg_src, nf_xmm_src;
  logic [1:0]  nf_mem_src;
  logic        nf_is_branch, nf_is_jump, nf_illegal;

  instr_decode_queue #(.XLEN(32), .DEPTH(DEPTH), .ENABLE_F(1'b1)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .mem_idle(mem_idle),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .out_rs1_addr(out_rs1_addr), .out_rs2_addr(out_rs2_addr), .out_rs3_addr(out_rs3_addr),
    .out_rd_addr(out_rd_addr), .out_read_mem(out_read_mem), .out_write_mem(out_write_mem),
    .out_write_reg(out_write_reg), .out_write_xmm(out_write_xmm),
    .out_alu_a_src(out_alu_a_src), .out_alu_b_src(out_alu_b_src),
    .out_reg_write_src(out_reg_write_src), .out_xmm_write_src(out_xmm_write_src),
    .out_mem_write_src(out_mem_write_src), .out_is_branch(out_is_branch),
    .out_is_jump(out_is_jump), .out_illegal(out_illegal)
  );

  instr_decode_queue #(.XLEN(32), .DEPTH(DEPTH), .ENABLE_F(1'b0)) u_nof (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(nf_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .mem_idle(mem_idle),
    .out_valid(nf_out_valid), .out_ready(out_ready), .out_pc(nf_out_pc), .out_instr(nf_out_instr),
    .out_rs1_addr(nf_rs1), .out_rs2_addr(nf_rs2), .out_rs3_addr(nf_rs3),
    .out_rd_addr(nf_rd), .out_read_mem(nf_read_mem), .out_write_mem(nf_write_mem),
    .out_write_reg(nf_write_reg), .out_write_xmm(nf_write_xmm),
    .out_alu_a_src(nf_alu_a), .out_alu_b_src(nf_alu_b),
    .out_reg_write_src(nf_reg_src), .out_xmm_write_src(nf_xmm_src),
    .out_mem_write_src(nf_mem_src), .out_is_branch(nf_is_branch),
    .out_is_jump(nf_is_jump), .out_illegal(nf_illegal)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rs1, rs2, rs3, rd;
    logic        rm, wm, wr, wx;
    logic [2:0]  a, b, rsrc, xsrc;
    logic [1:0]  msrc;
    logic        br, jp, ill;
  } exp_t;

  exp_t obs, obs_nf;
  assign obs = {out_pc, out_instr, out_rs1_addr, out_rs2_addr, out_rs3_addr, out_rd_addr,
                out_read_mem, out_write_mem, out_write_reg, out_write_xmm,
                out_alu_a_src, out_alu_b_src, out_reg_write_src, out_xmm_write_src,
                out_mem_write_src, out_is_branch, out_is_jump, out_illegal};
  assign obs_nf = {nf_out_pc, nf_out_instr, nf_rs1, nf_rs2, nf_rs3, nf_rd,
                   nf_read_mem, nf_write_mem, nf_write_reg, nf_write_xmm,
                   nf_alu_a, nf_alu_b, nf_reg_src, nf_xmm_src,
                   nf_mem_src, nf_is_branch, nf_is_jump, nf_illegal};

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  exp_t qn[$];
  bit   fwait;

  // Reference decode straight from the opcode table.
  // Selector codes: ZERO0 PC+4 1 PC2 REG3 IMM12 4 IMM20 5 XMM6;
  // reg: FPU_U32 0 FPU_I32 1 ALU2 MEM4 FPU_FP32 6; xmm: U32 0 I32 1 FP32 2 MEM4 FPU6.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc, input bit enf);
    exp_t e;
    bit   ill;
    e   = '0;
    ill = (ins[1:0] != 2'b11);
    if (!ill) begin
      case (ins[6:2])
        5'h00: begin e.rm = 1; e.wr = 1; e.a = 3; e.b = 4; e.rsrc = 4; end
        5'h03: ;
        5'h04: begin e.wr = 1; e.a = 3; e.b = 4; e.rsrc = 2; end
        5'h05: begin e.wr = 1; e.a = 2; e.b = 5; e.rsrc = 2; end
        5'h08: begin e.wm = 1; e.a = 3; e.b = 4; e.msrc = 1; end
        5'h0C: begin e.wr = 1; e.a = 3; e.b = 3; e.rsrc = 2; end
        5'h0D: begin e.wr = 1; e.a = 0; e.b = 5; e.rsrc = 2; end
        5'h18: begin e.a = 3; e.b = 3; e.br = 1; end
        5'h19, 5'h1B: begin e.wr = 1; e.a = 1; e.b = 0; e.rsrc = 2; e.jp = 1; end
        5'h01: if (enf) begin e.rm = 1; e.wx = 1; e.a = 3; e.b = 4; e.xsrc = 4; end else ill = 1;
        5'h09: if (enf) begin e.wm = 1; e.a = 3; e.b = 4; e.msrc = 2; end else ill = 1;
        5'h10, 5'h11, 5'h12, 5'h13:
          if (enf) begin e.wx = 1; e.a = 6; e.b = 6; e.xsrc = 6; end else ill = 1;
        5'h14:
          if (!enf) ill = 1;
          else case (ins[31:27])
            5'h14: begin e.wr = 1; e.rsrc = 1; end
            5'h18: begin e.wr = 1; e.rsrc = ins[20] ? 3'd0 : 3'd1; end
            5'h1C: begin e.wr = 1; e.rsrc = 6; end
            5'h1A: begin e.wx = 1; e.a = 3; e.b = 0; e.xsrc = ins[20] ? 3'd0 : 3'd1; end
            5'h1E: begin e.wx = 1; e.a = 3; e.b = 0; e.xsrc = 2; end
            default: begin e.wx = 1; e.a = 6; e.b = 6; e.xsrc = 6; end
          endcase
        default: ill = 1;
      endcase
    end
    if (ill) begin
      e     = '0;
      e.ill = 1;
    end
    e.pc = pc; e.instr = ins;
    e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rs3 = ins[31:27]; e.rd = ins[11:7];
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [4:0]  op;
    logic [4:0]  f5;
    r  = $urandom;
    f5 = r[31:27];
    case ($urandom_range(0, 18))
      0: op = 5'h00;  1: op = 5'h01;  2: op = 5'h03;  3: op = 5'h04;  4: op = 5'h05;
      5: op = 5'h08;  6: op = 5'h09;  7: op = 5'h0C;  8: op = 5'h0D;  9: op = 5'h10;
      10: op = 5'h11; 11: op = 5'h12; 12: op = 5'h13; 13: op = 5'h14; 14: op = 5'h18;
      15: op = 5'h19; 16: op = 5'h1B; 17: op = 5'h02; default: op = 5'h1F;
    endcase
    if (op == 5'h14 && $urandom_range(0, 3) != 0) begin
      case ($urandom_range(0, 4))
        0: f5 = 5'h14; 1: f5 = 5'h18; 2: f5 = 5'h1C; 3: f5 = 5'h1A; default: f5 = 5'h1E;
      endcase
    end
    r[31:27] = f5;
    r[6:2]   = op;
    r[1:0]   = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
    return r;
  endfunction

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; mem_idle = 1'b1;
    in_instr = '0; in_pc = '0;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (obs !== '0) begin errors++; $display("FAIL reset_fields: got %h want 0", obs); end
    reset = 1'b0;
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release: got valid=%b ready=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_addi();
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h0050_0093; in_pc = 32'h100;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL addi_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid: got %b want 1", out_valid); end
    checks++; if ({out_write_reg, out_alu_a_src, out_alu_b_src, out_reg_write_src} !== {1'b1, 3'd3, 3'd4, 3'd2}) begin
      errors++; $display("FAIL addi_ctrl: got wr=%b a=%0d b=%0d src=%0d want 1/3/4/2",
                         out_write_reg, out_alu_a_src, out_alu_b_src, out_reg_write_src);
    end
    checks++; if (out_pc !== 32'h100 || out_rd_addr !== 5'd1 || out_illegal !== 1'b0) begin
      errors++; $display("FAIL addi_head: got pc=%h rd=%0d ill=%b want 100/1/0", out_pc, out_rd_addr, out_illegal);
    end
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL addi_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_full();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h0010_0093; in_pc = 32'h200;
    @(negedge clk);
    in_instr = 32'h0020_0093; in_pc = 32'h204;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_one: got ready=%b want 1", in_ready); end
    @(negedge clk);
    in_instr = 32'h0030_0093; in_pc = 32'h208;
    #1;
    checks++; if (in_ready !== 1'b0 || out_pc !== 32'h200) begin
      errors++; $display("FAIL full_two: got ready=%b pc=%h want 0/200", in_ready, out_pc);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_no_bypass: got ready=%b want 0", in_ready); end
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1 || out_pc !== 32'h204) begin
      errors++; $display("FAIL full_after_pop: got ready=%b pc=%h want 1/204", in_ready, out_pc);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0 || out_pc !== 32'h204) begin
      errors++; $display("FAIL full_refill: got ready=%b pc=%h want 0/204", in_ready, out_pc);
    end
    @(negedge clk); #1;
    checks++; if (out_pc !== 32'h208 || out_instr !== 32'h0030_0093) begin
      errors++; $display("FAIL full_third: got pc=%h instr=%h want 208/00300093", out_pc, out_instr);
    end
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_fence();
    @(negedge clk);
    out_ready = 1'b0; mem_idle = 1'b0; in_valid = 1'b1; in_instr = 32'h0000_000F; in_pc = 32'h300;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fence_accept: got %b want 1", in_ready); end
    @(negedge clk);
    in_instr = 32'h0050_0093; in_pc = 32'h304; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0 || out_instr !== 32'h0000_000F || out_illegal !== 1'b0) begin
      errors++; $display("FAIL fence_wait: got ready=%b instr=%h ill=%b want 0/0000000f/0", in_ready, out_instr, out_illegal);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 3) mem_idle = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        errors++; $display("FAIL fence_hold%0d: got ready=%b valid=%b want 0/0", i, in_ready, out_valid);
      end
    end
    @(negedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fence_release: got %b want 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h304) begin
      errors++; $display("FAIL fence_next: got valid=%b pc=%h want 1/304", out_valid, out_pc);
    end
    @(negedge clk);
  endtask

  task automatic test_enable_f();
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h0001_2087; in_pc = 32'h400;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++; if ({out_read_mem, out_write_xmm, out_xmm_write_src, out_alu_a_src, out_alu_b_src, out_illegal}
                  !== {1'b1, 1'b1, 3'd4, 3'd3, 3'd4, 1'b0}) begin
      errors++; $display("FAIL flw_f: got rm=%b wx=%b xs=%0d a=%0d b=%0d ill=%b want 1/1/4/3/4/0",
                         out_read_mem, out_write_xmm, out_xmm_write_src, out_alu_a_src, out_alu_b_src, out_illegal);
    end
    checks++; if ({nf_out_valid, nf_illegal, nf_read_mem, nf_write_xmm, nf_xmm_src, nf_alu_a, nf_alu_b}
                  !== {1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0}) begin
      errors++; $display("FAIL flw_nof: got v=%b ill=%b rm=%b wx=%b xs=%0d a=%0d b=%0d want 1/1/0/0/0/0/0",
                         nf_out_valid, nf_illegal, nf_read_mem, nf_write_xmm, nf_xmm_src, nf_alu_a, nf_alu_b);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back_fp();
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'hC010_00D3; in_pc = 32'h500;
    @(negedge clk);
    in_instr = 32'h2031_00C3; in_pc = 32'h504;
    #1;
    checks++; if ({out_write_reg, out_write_xmm, out_reg_write_src, out_rd_addr} !== {1'b1, 1'b0, 3'd0, 5'd1}) begin
      errors++; $display("FAIL fcvt_wu: got wr=%b wx=%b rs=%0d rd=%0d want 1/0/0/1",
                         out_write_reg, out_write_xmm, out_reg_write_src, out_rd_addr);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++; if ({out_write_xmm, out_write_reg, out_rs3_addr, out_xmm_write_src, out_alu_a_src, out_alu_b_src, out_pc}
                  !== {1'b1, 1'b0, 5'd4, 3'd6, 3'd6, 3'd6, 32'h504}) begin
      errors++; $display("FAIL fmadd: got wx=%b wr=%b rs3=%0d xs=%0d a=%0d b=%0d pc=%h want 1/0/4/6/6/6/504",
                         out_write_xmm, out_write_reg, out_rs3_addr, out_xmm_write_src, out_alu_a_src, out_alu_b_src, out_pc);
    end
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fp_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_flush();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h0010_0093; in_pc = 32'h600;
    @(negedge clk);
    in_pc = 32'h604;
    @(negedge clk);
    flush = 1'b1; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL flush_assert: got ready=%b valid=%b want 0/1", in_ready, out_valid);
    end
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || obs !== '0) begin
      errors++; $display("FAIL flush_empty: got valid=%b ready=%b fields=%h want 0/1/0", out_valid, in_ready, obs);
    end
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'h0000_000F; mem_idle = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_fence_wait: got %b want 0", in_ready); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_fence_exit: got ready=%b valid=%b want 1/0", in_ready, out_valid);
    end
    mem_idle = 1'b1;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h0050_0093; in_pc = 32'h700;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL areset_pre: got %b want 1", out_valid); end
    #1 reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || obs !== '0) begin
      errors++; $display("FAIL areset_now: got valid=%b ready=%b fields=%h want 0/1/0", out_valid, in_ready, obs);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_random(input int n);
    bit   rdy, nf;
    exp_t e0, e1;
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    q.delete(); qn.delete(); fwait = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      flush     = ($urandom_range(0, 39) == 0);
      in_valid  = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 3) != 0);
      mem_idle  = ($urandom_range(0, 3) != 0);
      in_instr  = rand_instr();
      in_pc     = $urandom;
      #1;
      rdy = (q.size() < DEPTH) && !fwait && !flush;
      e0  = (q.size() != 0) ? q[0] : '0;
      e1  = (qn.size() != 0) ? qn[0] : '0;
      checks++; if (in_ready !== rdy) begin
        errors++; $display("FAIL rand_in_ready cyc%0d: got %b want %b", i, in_ready, rdy);
      end
      checks++; if (out_valid !== (q.size() != 0)) begin
        errors++; $display("FAIL rand_out_valid cyc%0d: got %b want %b", i, out_valid, q.size() != 0);
      end
      checks++; if (obs !== e0) begin
        errors++; $display("FAIL rand_head cyc%0d: got %h want %h", i, obs, e0);
      end
      checks++; if (obs_nf !== e1) begin
        errors++; $display("FAIL rand_head_nof cyc%0d: got %h want %h", i, obs_nf, e1);
      end
      if (flush) begin
        q.delete(); qn.delete(); fwait = 1'b0;
      end else begin
        nf = fwait && !(q.size() == 0 && mem_idle);
        if (q.size() != 0 && out_ready) begin q.delete(0); qn.delete(0); end
        if (in_valid && rdy) begin
          q.push_back(model(in_instr, in_pc, 1'b1));
          qn.push_back(model(in_instr, in_pc, 1'b0));
          if (in_instr[1:0] == 2'b11 && in_instr[6:2] == 5'h03) nf = 1'b1;
        end
        fwait = nf;
      end
    end
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_addi();
    test_full();
    test_fence();
    test_enable_f();
    test_back_to_back_fp();
    test_flush();
    test_async_reset();
    test_random(3000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
